csa_accum: RTL

Parametrised, sequential carry-save accumulator for the NPC multiply/divide datapath. Each accepted beat folds LANES operands into a redundant sum/carry state through a chain of 3:2 compressors, with optional per-lane negation. On the last beat, a multi-cycle chunked carry-propagate adder resolves the state and presents a binary result under a valid/ready handshake. It generalises the fixed-width 3:2 carry-save stage to arbitrary width, lane count and streaming accumulation.

---
 rtl/csa_accum.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/csa_accum.sv
// ---------------------------------------------------------------------------
// csa_accum
//
// Streaming carry-save accumulator. Every accepted beat folds LANES operands
// into a redundant (sum, carry) state through a chain of 3:2 compressors.
// Each lane can be negated. After the last beat of a packet, a chunked
// carry-propagate adder resolves CPA_W bits per cycle. The binary result is
// then held under a valid/ready handshake until the consumer takes it.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   accumulator can accept a beat (ACC state)
//   in_data    LANES operands, lane i at [i*WIDTH +: WIDTH]
//   in_neg     per-lane subtract select
//   in_last    beat closes the packet
//   out_valid  out_sum holds a resolved result
//   out_ready  consumer accepts the result
//   out_sum    resolved sum modulo 2^WIDTH
// ---------------------------------------------------------------------------
module csa_accum #(
    parameter int WIDTH = 132,
    parameter int LANES = 3,
    parameter int CPA_W = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_neg,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum
);

    localparam int NCHUNK = (WIDTH + CPA_W - 1) / CPA_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OFFW   = $clog2(NCHUNK * CPA_W + 1);

    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CPA_W{1'b1}});

    typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic             carry_q, carry_d;

    // ------------------------------------------------------------------
    // Compressor chain: lane by lane, (S, C, x_i) -> (S', C').
    // Negation is ~x plus one. The +1 rides in bit 0 of the shifted
    // carry, which is always free after the shift.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s_chain, c_chain, x, maj;

    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path leaves it holding its old value (which would infer a latch).
    always_comb begin
        s_chain = s_q;
        c_chain = c_q;
        x       = '0;
        maj     = '0;
        for (int i = 0; i < LANES; i++) begin
            x       = in_neg[i] ? ~in_data[i*WIDTH +: WIDTH] : in_data[i*WIDTH +: WIDTH];
            maj     = (s_chain & c_chain) | (s_chain & x) | (c_chain & x);
            s_chain = s_chain ^ c_chain ^ x;
            c_chain = (maj << 1) | WIDTH'(in_neg[i]);
        end
    end

    // ------------------------------------------------------------------
    // Chunked resolve: this cycle's CPA_W-bit slice of S and C plus the
    // carry from the previous chunk. Bits above WIDTH in the last chunk
    // are shifted in as zeros, so a narrower final chunk needs no special case.
    // ------------------------------------------------------------------
    logic [OFFW-1:0]  off;
    logic [CPA_W-1:0] s_slice, c_slice;
    logic [CPA_W:0]   chunk_sum;

    always_comb begin
        off       = OFFW'(chunk_q) * OFFW'(CPA_W);
        s_slice   = CPA_W'(s_q >> off);
        c_slice   = CPA_W'(c_q >> off);
        chunk_sum = {1'b0, s_slice} + {1'b0, c_slice} + (CPA_W+1)'(carry_q);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        res_d   = res_q;
        chunk_d = chunk_q;
        carry_d = carry_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    s_d = s_chain;
                    c_d = c_chain;
                    if (in_last) begin
                        state_d = RESOLVE;
                        chunk_d = '0;
                        carry_d = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                res_d   = (res_q & ~(CHUNK_MASK << off))
                        | (WIDTH'(chunk_sum[CPA_W-1:0]) << off);
                carry_d = chunk_sum[CPA_W];
                chunk_d = chunk_q + CW'(1);
                if (chunk_q == CW'(NCHUNK - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    res_d   = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value no matter how the blocks are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            chunk_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
            chunk_q <= chunk_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = res_q;

endmodule
